// File: rtl/xadc_temp_sampler_if.sv
// DRP read port and averaged-sample outputs of the XADC temperature sampler.
// master = sampler side, slave = XADC/consumer side.
interface xadc_temp_sampler_if;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [15:0] sample_q15;
  logic        sample_vld;
  logic [11:0] raw_code_dbg;
  logic        timeout_err;
  logic        overrun_err;

  modport master (
    output drp_den, drp_dwe, drp_daddr, drp_di,
    output sample_q15, sample_vld, raw_code_dbg, timeout_err, overrun_err,
    input  drp_do, drp_drdy
  );

  modport slave (
    input  drp_den, drp_dwe, drp_daddr, drp_di,
    input  sample_q15, sample_vld, raw_code_dbg, timeout_err, overrun_err,
    output drp_do, drp_drdy
  );
endinterface

// File: rtl/xadc_temp_sampler.sv
// Periodic DRP reads of the XADC temperature channel, box-car averaged and scaled to Q1.15.
// sample_vld two cycles after the final drdy; no backpressure, overrun and timeout flagged sticky.
module xadc_temp_sampler #(
  parameter logic [6:0]         DRP_ADDR    = 7'h13,
  parameter int unsigned        SAMPLE_DIV  = 100_000,
  parameter int unsigned        AVG_LOG2    = 4,
  parameter logic [15:0]        SCALE_Q8    = 16'd2048,
  parameter logic signed [15:0] OFFSET_Q15  = 16'sd0,
  parameter int unsigned        DRP_TIMEOUT = 64
) (
  input logic                 clk_100mhz,
  input logic                 rst,
  xadc_temp_sampler_if.master bus
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACCUM, S_SCALE} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TMO_W-1:0] tmo_q;
  logic [11:0]      code_q;
  logic [11:0]      raw_code_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             den_q, vld_q, timeout_err_q, overrun_err_q;
  logic [15:0]      sample_q;

  logic               trig;
  logic [11:0]        mean;
  logic [27:0]        prod;
  logic signed [20:0] scaled;
  logic [15:0]        sample_d;
  logic               unused_bits;

  // Free-running divider; never stalled by the FSM.
  assign trig  = (div_q == DIV_LAST);
  assign div_d = trig ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk_100mhz) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  always_comb begin
    mean     = acc_q[ACC_W-1:AVG_LOG2];
    prod     = {16'd0, mean} * {12'd0, SCALE_Q8};
    scaled   = $signed({1'b0, prod[27:8]}) + $signed({{5{OFFSET_Q15[15]}}, OFFSET_Q15});
    sample_d = scaled[15:0];
    if (scaled < 0)                sample_d = 16'h0000;
    else if (scaled > 21'sd32767)  sample_d = 16'h7FFF;
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      code_q        <= '0;
      raw_code_q    <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      den_q         <= 1'b0;
      vld_q         <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      sample_q      <= '0;
    end else begin
      den_q <= 1'b0;
      vld_q <= 1'b0;
      if (trig && state_q != S_IDLE) overrun_err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (trig) begin
            state_q <= S_REQ;
            den_q   <= 1'b1;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
          tmo_q   <= '0;
        end
        S_WAIT: begin
          // drdy takes priority over an expiring timeout in the same cycle
          if (bus.drp_drdy) begin
            code_q     <= bus.drp_do[15:4];
            raw_code_q <= bus.drp_do[15:4];
            state_q    <= S_ACCUM;
          end else if (tmo_q == TMO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_ACCUM: begin
          acc_q   <= acc_q + ACC_W'(code_q);
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= (cnt_q == CNT_LAST) ? S_SCALE : S_IDLE;
        end
        S_SCALE: begin
          sample_q <= sample_d;
          vld_q    <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.drp_den      = den_q;
  assign bus.drp_dwe      = 1'b0;
  assign bus.drp_daddr    = DRP_ADDR;
  assign bus.drp_di       = 16'h0000;
  assign bus.sample_q15   = sample_q;
  assign bus.sample_vld   = vld_q;
  assign bus.raw_code_dbg = raw_code_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.overrun_err  = overrun_err_q;

  assign unused_bits = ^{bus.drp_do[3:0], prod[7:0]};
endmodule

// File: tb/tb_xadc_temp_sampler.sv
// Bench for xadc_temp_sampler: three lock-stepped instances (offsets 0, +2000, -100) on one DRP
// responder with a scoreboard, plus a fast-trigger instance for overrun and mid-transaction reset.
module tb_xadc_temp_sampler;
  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  xadc_temp_sampler_if a_bus ();
  xadc_temp_sampler_if b_bus ();
  xadc_temp_sampler_if c_bus ();
  xadc_temp_sampler_if d_bus ();

  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [15:0] d_do;
  logic        d_drdy;

  assign a_bus.drp_do = drp_do;  assign a_bus.drp_drdy = drp_drdy;
  assign b_bus.drp_do = drp_do;  assign b_bus.drp_drdy = drp_drdy;
  assign c_bus.drp_do = drp_do;  assign c_bus.drp_drdy = drp_drdy;
  assign d_bus.drp_do = d_do;    assign d_bus.drp_drdy = d_drdy;

  xadc_temp_sampler #(.SAMPLE_DIV(20)) u_a (.clk_100mhz(clk_100mhz), .rst(rst), .bus(a_bus));
  xadc_temp_sampler #(.SAMPLE_DIV(20), .OFFSET_Q15(16'sd2000))
    u_b (.clk_100mhz(clk_100mhz), .rst(rst), .bus(b_bus));
  xadc_temp_sampler #(.SAMPLE_DIV(20), .OFFSET_Q15(-16'sd100))
    u_c (.clk_100mhz(clk_100mhz), .rst(rst), .bus(c_bus));
  xadc_temp_sampler #(.SAMPLE_DIV(4)) u_d (.clk_100mhz(clk_100mhz), .rst(rst), .bus(d_bus));

  typedef struct { logic [11:0] code; bit drop; } stim_t;
  typedef struct { logic [2:0][15:0] val; int cyc; } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rsp_en = 1'b0;
  bit    drop_seen = 1'b0;
  int    drop_den_cyc = 0;
  int    acc_m = 0;
  int    cnt_m = 0;
  logic [2:0][15:0] got;
  logic [2:0]       got_vld;
  int               vld_cyc = 0;

  function automatic logic [15:0] model_q15(input int acc, input int off);
    int v;
    v = (acc / 16) * 8 + off;
    if (v < 0) v = 0;
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  // DRP slave for instances a/b/c: drdy sampled 3 cycles after den; expectations pushed on delivery.
  initial begin : responder
    stim_t s;
    exp_t  e;
    int    den_cyc;
    drp_do   = '0;
    drp_drdy = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (rsp_en && a_bus.drp_den === 1'b1) begin
        den_cyc = cyc;
        repeat (2) @(negedge clk_100mhz);
        if (stim_q.size() > 0) begin
          s = stim_q.pop_front();
          if (s.drop) begin
            drop_den_cyc = den_cyc;
            drop_seen    = 1'b1;
          end else begin
            drp_do   = {s.code, 4'h5};
            drp_drdy = 1'b1;
            acc_m += int'(s.code);
            cnt_m++;
            if (cnt_m == 16) begin
              e.val[0] = model_q15(acc_m, 0);
              e.val[1] = model_q15(acc_m, 2000);
              e.val[2] = model_q15(acc_m, -100);
              e.cyc    = cyc + 3;
              exp_q.push_back(e);
              acc_m = 0;
              cnt_m = 0;
            end
            @(negedge clk_100mhz);
            drp_drdy = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_vld(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_100mhz);
      if (a_bus.sample_vld === 1'b1) begin
        ok      = 1'b1;
        got[0]  = a_bus.sample_q15;
        got[1]  = b_bus.sample_q15;
        got[2]  = c_bus.sample_q15;
        got_vld = {c_bus.sample_vld, b_bus.sample_vld, a_bus.sample_vld};
        vld_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    logic [48:0] snap;
    int a_first, d_first;
    rst = 1'b1;
    repeat (5) @(negedge clk_100mhz);
    snap = {a_bus.drp_den, a_bus.drp_dwe, a_bus.drp_di, a_bus.sample_q15, a_bus.sample_vld,
            a_bus.raw_code_dbg, a_bus.timeout_err, a_bus.overrun_err};
    checks++;
    if (snap !== '0) begin
      errors++; $display("FAIL reset_outputs_a: got %h required 0", snap);
    end
    snap = {d_bus.drp_den, d_bus.drp_dwe, d_bus.drp_di, d_bus.sample_q15, d_bus.sample_vld,
            d_bus.raw_code_dbg, d_bus.timeout_err, d_bus.overrun_err};
    checks++;
    if (snap !== '0) begin
      errors++; $display("FAIL reset_outputs_d: got %h required 0", snap);
    end
    checks++;
    if (a_bus.drp_daddr !== 7'h13) begin
      errors++; $display("FAIL reset_daddr: got %h required 13", a_bus.drp_daddr);
    end
    rst = 1'b0;
    a_first = -1;
    d_first = -1;
    for (int i = 1; i <= 40 && a_first < 0; i++) begin
      @(negedge clk_100mhz);
      if (a_bus.drp_den === 1'b1 && a_first < 0) a_first = i;
      if (d_bus.drp_den === 1'b1 && d_first < 0) d_first = i;
    end
    checks++;
    if (a_first !== 20) begin
      errors++; $display("FAIL first_den_div20: got cycle %0d required 20", a_first);
    end
    checks++;
    if (d_first !== 4) begin
      errors++; $display("FAIL first_den_div4: got cycle %0d required 4", d_first);
    end
  endtask

  task automatic test_average(input string tag, input logic [11:0] c0, input logic [11:0] c1);
    stim_t s;
    exp_t  e;
    bit    ok;
    for (int i = 0; i < 16; i++) begin
      s.code = (i < 8) ? c0 : c1;
      s.drop = 1'b0;
      stim_q.push_back(s);
    end
    wait_vld(16 * 20 + 60, ok);
    checks++;
    if (!ok || exp_q.size() != 1) begin
      errors++;
      $display("FAIL %s_strobe: seen=%0b queued=%0d required seen=1 queued=1", tag, ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== e.val[k]) begin
          errors++; $display("FAIL %s_q15_inst%0d: got %0d required %0d", tag, k, got[k], e.val[k]);
        end
      end
      checks++;
      if (vld_cyc !== e.cyc) begin
        errors++; $display("FAIL %s_latency: strobe at %0d required %0d", tag, vld_cyc, e.cyc);
      end
      checks++;
      if (got_vld !== 3'b111) begin
        errors++; $display("FAIL %s_vld_all: got %b required 111", tag, got_vld);
      end
      checks++;
      if (a_bus.raw_code_dbg !== c1) begin
        errors++; $display("FAIL %s_raw_code: got %h required %h", tag, a_bus.raw_code_dbg, c1);
      end
      @(negedge clk_100mhz);
      checks++;
      if (a_bus.sample_vld !== 1'b0 || a_bus.sample_q15 !== e.val[0]) begin
        errors++;
        $display("FAIL %s_hold: vld=%b q15=%0d required vld=0 q15=%0d", tag, a_bus.sample_vld,
                 a_bus.sample_q15, e.val[0]);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    exp_t  e;
    bit    ok;
    drop_seen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s.code = 12'h100 + 12'(i * 17);
      s.drop = (i == 2);
      stim_q.push_back(s);
    end
    for (int i = 0; i < 200 && !drop_seen; i++) @(negedge clk_100mhz);
    checks++;
    if (!drop_seen) begin
      errors++; $display("FAIL timeout_drop: suppressed read not reached, required within 200 cycles");
    end else begin
      while (cyc < drop_den_cyc + 63) @(negedge clk_100mhz);
      checks++;
      if (a_bus.timeout_err !== 1'b0) begin
        errors++; $display("FAIL timeout_early: got %b at den+63 required 0", a_bus.timeout_err);
      end
      while (cyc < drop_den_cyc + 65) @(negedge clk_100mhz);
      checks++;
      if (a_bus.timeout_err !== 1'b1) begin
        errors++; $display("FAIL timeout_set: got %b at den+65 required 1", a_bus.timeout_err);
      end
    end
    wait_vld(17 * 20 + 200, ok);
    checks++;
    if (!ok || exp_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_strobe: seen=%0b queued=%0d required seen=1 queued=1", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== e.val[k]) begin
          errors++; $display("FAIL timeout_q15_inst%0d: got %0d required %0d", k, got[k], e.val[k]);
        end
      end
      checks++;
      if (vld_cyc !== e.cyc) begin
        errors++; $display("FAIL timeout_latency: strobe at %0d required %0d", vld_cyc, e.cyc);
      end
    end
    checks++;
    if ({a_bus.timeout_err, a_bus.overrun_err} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_sticky: got t=%b o=%b required t=1 o=1", a_bus.timeout_err, a_bus.overrun_err);
    end
  endtask

  task automatic test_overrun_reset();
    bit found;
    int den_cnt, stray, last_drive;
    rsp_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_100mhz);
      found = (d_bus.drp_den === 1'b1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL ovr_den: no den within 20 cycles, required one");
    end
    den_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_100mhz);
      if (d_bus.drp_den === 1'b1) den_cnt++;
    end
    checks++;
    if (den_cnt !== 0 || d_bus.overrun_err !== 1'b1) begin
      errors++;
      $display("FAIL ovr_wait: dens=%0d overrun=%b required dens=0 overrun=1", den_cnt, d_bus.overrun_err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    rst    = 1'b0;
    d_do   = 16'hABC0;
    d_drdy = 1'b1;
    @(negedge clk_100mhz);
    d_drdy = 1'b0;
    checks++;
    if ({d_bus.raw_code_dbg, d_bus.timeout_err, d_bus.overrun_err, a_bus.timeout_err, a_bus.overrun_err}
        !== '0) begin
      errors++;
      $display("FAIL ovr_after_reset: raw=%h flags d=%b%b a=%b%b required all 0", d_bus.raw_code_dbg,
               d_bus.timeout_err, d_bus.overrun_err, a_bus.timeout_err, a_bus.overrun_err);
    end
    stray = 0;
    last_drive = 0;
    for (int j = 0; j < 16 && found; j++) begin
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        @(negedge clk_100mhz);
        if (d_bus.sample_vld === 1'b1) stray++;
        found = (d_bus.drp_den === 1'b1);
      end
      @(negedge clk_100mhz);
      d_do       = 16'h0100;
      d_drdy     = 1'b1;
      last_drive = cyc;
      @(negedge clk_100mhz);
      d_drdy = 1'b0;
    end
    checks++;
    if (!found || stray != 0) begin
      errors++; $display("FAIL ovr_reads: den_ok=%0b early_strobes=%0d required 1 and 0", found, stray);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_100mhz);
      found = (d_bus.sample_vld === 1'b1);
    end
    checks++;
    if (!found || cyc !== last_drive + 3 || d_bus.sample_q15 !== 16'd128) begin
      errors++;
      $display("FAIL ovr_sample: seen=%0b at %0d q15=%0d required seen=1 at %0d q15=128", found, cyc,
               d_bus.sample_q15, last_drive + 3);
    end
    checks++;
    if (d_bus.raw_code_dbg !== 12'h010) begin
      errors++; $display("FAIL ovr_raw: got %h required 010", d_bus.raw_code_dbg);
    end
  endtask

  initial begin
    d_do   = '0;
    d_drdy = 1'b0;
    rsp_en = 1'b1;
    test_reset();
    test_average("nominal", 12'h800, 12'h800);
    test_average("mixed", 12'h001, 12'h002);
    test_average("sat_hi", 12'hFFF, 12'hFFF);
    test_average("sat_lo", 12'h00A, 12'h00A);
    test_timeout();
    test_overrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xadc_temp_sampler.md
Name: xadc_temp_sampler

Overview:
Upstream stage of temp_fan_ctrl. It issues periodic DRP reads to the XADC channel that carries the temperature sensor and box-car averages 2^AVG_LOG2 12-bit codes. It scales the mean into a saturated, non-negative Q1.15 sample and presents it as sample_q15 with a one-cycle sample_vld strobe. It also flags DRP timeouts and trigger overruns.

Parameters:
DRP_ADDR, 7'h13, XADC status register address read each request (VAUX3 result).
SAMPLE_DIV, 100_000, clk_100mhz cycles between read triggers (1 kHz).
AVG_LOG2, 4, log2 of samples per averaged output (16 reads per output, 62.5 Hz).
SCALE_Q8, 16'd2048, unsigned code-to-Q1.15 gain in Q8.8 (×8.0).
OFFSET_Q15, 16'sd0, signed Q1.15 offset added after scaling.
DRP_TIMEOUT, 64, max cycles waiting for drp_drdy before abort.

Ports:
clk_100mhz  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
drp_den  out  1  DRP enable, one-cycle pulse per read
drp_dwe  out  1  DRP write enable, tied 0
drp_daddr  out  7  DRP address, constant DRP_ADDR
drp_di  out  16  DRP write data, tied 0
drp_do  in  16  DRP read data; code in [15:4]
drp_drdy  in  1  DRP data-ready strobe
sample_q15  out  16  averaged, scaled temperature, Q1.15, range [0, 0x7FFF]
sample_vld  out  1  one-cycle strobe; sample_q15 is new
raw_code_dbg  out  12  last captured raw code
timeout_err  out  1  sticky; drp_drdy not seen within DRP_TIMEOUT
overrun_err  out  1  sticky; trigger arrived while FSM not IDLE

Behaviour:
- Reset values: all outputs 0, including sample_q15, sample_vld, drp_den, raw_code_dbg and both error flags. Reset also clears the divider, the accumulator and the sample count, and forces the FSM to IDLE. This holds mid-transaction; a drp_drdy arriving after reset is ignored.
- Trigger: free-running divider pulses trig for one cycle when the count reaches SAMPLE_DIV-1, then wraps to 0.
- FSM states: IDLE, REQ, WAIT, ACCUM, SCALE.
- IDLE: on trig go to REQ.
- REQ: drive drp_den=1 for exactly this cycle, go to WAIT, clear the timeout counter.
- WAIT: on drp_drdy capture drp_do[15:4] into raw_code_dbg and the code register, then go to ACCUM. If the timeout counter reaches DRP_TIMEOUT-1 with no drdy: set timeout_err, return to IDLE, leave accumulator and count unchanged.
- ACCUM: acc += code, where acc is 12+AVG_LOG2 bits and cannot overflow; cnt += 1. If cnt was 2^AVG_LOG2-1, go to SCALE; otherwise go to IDLE.
- SCALE: mean = acc >> AVG_LOG2 (12 bits). Compute prod = mean*SCALE_Q8 (28 bits), then v = (prod >> 8) + sign-extended OFFSET_Q15 in 21-bit signed arithmetic. Saturate v to [0, 32767] and register it into sample_q15. Pulse sample_vld for 1 cycle, clear acc and cnt, go to IDLE.
- Latency: sample_vld asserts on the 2nd rising edge after the clock edge at which the final drp_drdy is sampled. sample_q15 holds its value between strobes.
- trig while not IDLE: the trig is dropped and overrun_err is set. The divider is not stalled.
- drp_drdy outside WAIT: ignored.
- drdy and timeout in the same cycle: drdy wins, no error.
- Sticky flags clear only on rst.
- At most one DRP transaction is outstanding; drp_den is never asserted in back-to-back cycles.

Test Plan:
- Reset/idle: hold rst for 5 cycles, then release. All outputs are 0 and the first drp_den appears exactly SAMPLE_DIV cycles after release.
- Nominal average: use SAMPLE_DIV=20 and model drdy 3 cycles after den with drp_do=16'h8000 (code 0x800) for 16 reads. Expect one sample_vld with sample_q15=16'd16384, 2 cycles after the 16th drdy. raw_code_dbg=0x800.
- Saturation: set OFFSET_Q15=16'sd2000 and code 0xFFF. mean*8=32760, +2000 saturates, so expect 0x7FFF. Set OFFSET_Q15=-16'sd100 and code 0x00A. 80-100 is negative, so expect 0.
- Mixed average/truncation: 8 reads of code 0x001 and 8 reads of 0x002. acc=24, mean=1, so expect sample_q15=8.
- Timeout: suppress drdy on the 3rd read. timeout_err rises 64 cycles after that den and the count is not advanced. The output still arrives after 16 successful reads, with the value unaffected.
- Overrun and reset mid-operation: use SAMPLE_DIV=4 and drdy latency 10, so overrun_err sets and no second den is issued during WAIT. Assert rst while in WAIT, then deliver drdy. No accumulation occurs and the flags clear.
